parking_request_scheduler: RTL

Sequences the shared car elevator of the parking lot by queuing entry and exit requests and serving them one at a time. It picks the next job, drives the elevator one floor per cycle, and loads and unloads the car plate. It stalls at leaking floors and reports completion to the slot-bookkeeping logic. It sits between the plate/mode input front end and the per-floor parked registers.

---
 rtl/parking_request_scheduler.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/parking_request_scheduler.sv
// parking_request_scheduler
// Queues car-elevator entry/exit requests and serves them one at a time.
// Exits win over entries and age breaks ties. The elevator moves one floor
// per cycle, loads and unloads the plate, and will not stop at a leaking
// floor. Each finished job is reported with a one-cycle done pulse.
module parking_request_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_out,
  input  logic [15:0] req_plate,
  input  logic [2:0]  req_floor,
  input  logic        leakage,
  input  logic [2:0]  leakage_floor,
  output logic [2:0]  current_floor,
  output logic [15:0] moving,
  output logic        busy,
  output logic        done_valid,
  output logic [15:0] done_plate,
  output logic [2:0]  done_floor,
  output logic        done_out,
  output logic        reject
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TO_PICK,
    LOAD,
    TO_DROP,
    UNLOAD
  } state_t;

  state_t state;

  // Request queue, kept compacted: slot 0 is the oldest entry.
  logic [15:0]   q_plate [DEPTH];
  logic [2:0]    q_floor [DEPTH];
  logic          q_out   [DEPTH];
  logic [CW-1:0] count;

  logic [15:0]   n_plate [DEPTH];
  logic [2:0]    n_floor [DEPTH];
  logic          n_out   [DEPTH];
  logic [CW-1:0] n_count;
  logic [CW-1:0] wr_idx;

  // Latched job currently being served.
  logic [15:0] job_plate;
  logic [2:0]  job_floor;
  logic        job_out;

  logic [2:0]  leak_floor;
  logic        dup;
  logic        discard;
  logic        accept;
  logic        bad;
  logic        sel_valid;
  logic [IW-1:0] sel_idx;
  logic [15:0] sel_plate;
  logic [2:0]  sel_floor;
  logic        sel_out;
  logic        dispatch;
  logic [2:0]  pick_floor;
  logic [2:0]  drop_floor;
  logic        stall_pick;
  logic        stall_drop;

  // One-floor move toward the destination; callers never ask when already there.
  function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] dst);
    if (dst > cur) step_toward = cur + 3'd1;
    else           step_toward = cur - 3'd1;
  endfunction

  // Ready depends on the pre-edge count, so a full queue never accepts and removes on one edge.
  assign req_ready = (count < DEPTH_C) & reset;

  // Leakage floor 0 means "no leaking floor". Queued floors are never 0,
  // so a zero here can never match a job.
  assign leak_floor = (leakage && (leakage_floor != 3'd0)) ? leakage_floor : 3'd0;

  assign pick_floor = job_out ? job_floor : 3'd0;
  assign drop_floor = job_out ? 3'd0 : job_floor;
  assign stall_pick = (leak_floor != 3'd0) && (pick_floor == leak_floor);
  assign stall_drop = (leak_floor != 3'd0) && (drop_floor == leak_floor);

  // Classify an offered request: duplicate plate against queue and car, or invalid fields.
  always_comb begin
    dup = (req_plate == moving);
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (q_plate[i] == req_plate)) dup = 1'b1;
    end
    discard = (req_floor == 3'd0) || (req_plate == 16'd0) || dup;
    accept  = req_valid & req_ready & ~discard;
    bad     = req_valid & req_ready & discard;
  end

  // Pick the oldest eligible exit, or failing that the oldest eligible entry.
  always_comb begin
    logic          found_exit;
    logic          found_entry;
    logic [IW-1:0] exit_idx;
    logic [IW-1:0] entry_idx;
    found_exit  = 1'b0;
    found_entry = 1'b0;
    exit_idx    = '0;
    entry_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (q_floor[i] != leak_floor)) begin
        if (q_out[i] && !found_exit) begin
          found_exit = 1'b1;
          exit_idx   = IW'(i);
        end
        if (!q_out[i] && !found_entry) begin
          found_entry = 1'b1;
          entry_idx   = IW'(i);
        end
      end
    end
    sel_valid = found_exit | found_entry;
    sel_idx   = found_exit ? exit_idx : entry_idx;
    sel_plate = 16'd0;
    sel_floor = 3'd0;
    sel_out   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IW'(i) == sel_idx) begin
        sel_plate = q_plate[i];
        sel_floor = q_floor[i];
        sel_out   = q_out[i];
      end
    end
  end

  assign dispatch = (state == IDLE) & sel_valid;
  assign wr_idx   = count - CW'(dispatch);

  // Next queue image: close the gap left by a dispatched job, then append an accepted request.
  always_comb begin
    n_count = wr_idx + CW'(accept);
    for (int i = 0; i < DEPTH; i++) begin
      n_plate[i] = q_plate[i];
      n_floor[i] = q_floor[i];
      n_out[i]   = q_out[i];
    end
    if (dispatch) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IW'(i) >= sel_idx) begin
          n_plate[i] = q_plate[(i + 1) % DEPTH];
          n_floor[i] = q_floor[(i + 1) % DEPTH];
          n_out[i]   = q_out[(i + 1) % DEPTH];
        end
      end
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          n_plate[i] = req_plate;
          n_floor[i] = req_floor;
          n_out[i]   = req_out;
        end
      end
    end
  end

  // Queue storage; only the occupancy count is reset, slot contents beyond it are don't-care.
  always_ff @(posedge clock) begin
    q_plate <= n_plate;
    q_floor <= n_floor;
    q_out   <= n_out;
    if (!reset) count <= '0;
    else        count <= n_count;
  end

  // Elevator sequencer with registered status, done and reject outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      current_floor <= 3'd0;
      moving        <= 16'd0;
      busy          <= 1'b0;
      done_valid    <= 1'b0;
      done_plate    <= 16'd0;
      done_floor    <= 3'd0;
      done_out      <= 1'b0;
      reject        <= 1'b0;
      job_plate     <= 16'd0;
      job_floor     <= 3'd0;
      job_out       <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      reject     <= bad;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            job_plate <= sel_plate;
            job_floor <= sel_floor;
            job_out   <= sel_out;
            busy      <= 1'b1;
            state     <= TO_PICK;
          end
        end
        TO_PICK: begin
          if (!stall_pick) begin
            if (current_floor == pick_floor) state <= LOAD;
            else current_floor <= step_toward(current_floor, pick_floor);
          end
        end
        LOAD: begin
          moving <= job_plate;
          state  <= TO_DROP;
        end
        TO_DROP: begin
          if (!stall_drop) begin
            if (current_floor == drop_floor) state <= UNLOAD;
            else current_floor <= step_toward(current_floor, drop_floor);
          end
        end
        UNLOAD: begin
          moving     <= 16'd0;
          done_valid <= 1'b1;
          done_plate <= job_plate;
          done_floor <= job_floor;
          done_out   <= job_out;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
